alu_seq: RTL and testbench
==========================

# alu_seq

Sequential ALU that sits directly downstream of the processor control unit: it consumes the 3-bit `alu_op` code and operands from the accumulator (AC) and the bus, and produces the result that the control unit's "ALU -> AC" write path loads into AC. It also produces the zero flag that the control unit tests for its conditional-jump states. Add, subtract and left shift complete in one cycle. Multiply is a 16-iteration shift-add engine with a start/busy/done handshake.

## Interface
- `WIDTH`, default 16: datapath width; fixed at 16 for this processor.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request strobe; sampled on a rising edge when `busy`=0.
- `alu_op`  in  3  0=NOP, 1=ADD, 2=SUB, 3=MULT, 4=LSHIFT, 5–7=reserved (treated as NOP).
- `a`  in  WIDTH  operand A (from AC).
- `b`  in  WIDTH  operand B (from bus / R).
- `result`  out  WIDTH  registered result, held until the next completed op.
- `z`  out  1  registered; 1 when `result`==0.
- `cout`  out  1  registered carry (ADD), borrow (SUB), or shifted-out MSB (LSHIFT).
- `busy`  out  1  high while a MULT iterates.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, MUL.
- IDLE, `start`=1, op in {1,2,4,0,5–7}:
  - ADD: `result`=a+b mod 2^16, `cout`=bit 16 of the sum.
  - SUB: `result`=a−b mod 2^16, `cout`=1 iff a<b (unsigned).
  - LSHIFT: `result`=a<<1, `cout`=a[15].
  - NOP/reserved: `result`, `z` and `cout` unchanged.
  - Every case: `done`=1 for one cycle; stay in IDLE.
- IDLE, `start`=1, op=3:
  - Latch `m`=a and `q`=b; clear accumulator `acc`; set `cnt`=0 and `busy`=1; go to MUL.
  - Operands are captured here, so `a`/`b` may change afterwards.
- MUL, each edge:
  - If q[0], `acc`=acc+m (mod 2^16).
  - Then `m`=m<<1, `q`=q>>1, `cnt`+=1.
  - When `cnt` reaches 15 (the 16th iteration), write the final `acc` to `result`, set `cout`=0, `done`=1, `busy`=0, and return to IDLE.
  - `result` is the low 16 bits of the unsigned product. Those bits are identical for two's-complement operands.
- `z` is recomputed from every newly written `result`.
- `start` while `busy`=1 is ignored; no queuing. `alu_op`, `a` and `b` are don't-care during MUL.
- `start`=0 in IDLE: no state change, `done`=0.

## Timing
- Reset (async assert, any state): `result`=0, `z`=1, `cout`=0, `busy`=0, `done`=0, state=IDLE, `cnt`/`acc`/`m`/`q`=0.
  - An in-flight MULT is aborted. No `done` is produced for it.
- Single-cycle ops: `start` sampled at edge N; `result`/`z`/`cout` valid and `done`=1 after edge N; `done` drops after edge N+1.
- MULT: `start` sampled at edge N; `busy`=1 after edge N; `result` valid, `done`=1 and `busy`=0 after edge N+16.
  - A new `start` is accepted at edge N+17. It is also accepted at edge N+16's successor cycle, since `busy` is already 0 then.
- Back-to-back single-cycle ops: `start` may be held high. One op completes per edge and `done` stays high.
- `done` and `busy` are never high in the same cycle.

## Test plan
- ADD: a=0x1234, b=0x0001, start one cycle → next cycle `result`=0x1235, `z`=0, `cout`=0, `done`=1 for exactly one cycle.
- ADD overflow / SUB zero:
  - 0xFFFF+0x0001 → `result`=0x0000, `z`=1, `cout`=1.
  - 5−5 → 0x0000, `z`=1, `cout`=0.
  - 3−5 → 0xFFFE, `cout`=1.
- MULT: a=300, b=200 → `busy` high for 16 cycles, then `result`=0xEA60 (60000), `z`=0, `done`=1 exactly 16 edges after start. Change `a`/`b` mid-operation and confirm the result is unaffected.
- MULT truncation: 0x0100×0x0100 → `result`=0x0000, `z`=1. Also 0xFFFF×0xFFFF → 0x0001.
- Busy protection: during a MULT, pulse `start` with ADD → ignored. Only the MULT `done` appears, and `result` equals the product.
- Reset mid-MULT: assert `rst_n`=0 asynchronously at iteration 8 → outputs immediately `result`=0, `z`=1, `busy`=0, `done`=0. After release, a LSHIFT of 0x8001 gives 0x0002 with `cout`=1.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU feeding the accumulator write path: one-cycle ADD/SUB/LSHIFT
// and a 16-iteration shift-add MULT with a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_MULT   = 3'd3;
  localparam logic [2:0] OP_LSHIFT = 3'd4;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] result_reg;
  logic             z_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] acc_next;

  // The extra top bit of the widened difference is the unsigned borrow.
  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};
  assign shl_val  = {a[WIDTH-2:0], 1'b0};
  assign acc_next = acc_reg + (q_reg[0] ? m_reg : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      z_reg      <= 1'b1;
      cout_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      m_reg      <= '0;
      q_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (alu_op)
              OP_ADD: begin
                result_reg <= add_sum[WIDTH-1:0];
                z_reg      <= (add_sum[WIDTH-1:0] == '0);
                cout_reg   <= add_sum[WIDTH];
                done_reg   <= 1'b1;
              end
              OP_SUB: begin
                result_reg <= sub_diff[WIDTH-1:0];
                z_reg      <= (sub_diff[WIDTH-1:0] == '0);
                cout_reg   <= sub_diff[WIDTH];
                done_reg   <= 1'b1;
              end
              OP_LSHIFT: begin
                result_reg <= shl_val;
                z_reg      <= (shl_val == '0);
                cout_reg   <= a[WIDTH-1];
                done_reg   <= 1'b1;
              end
              OP_MULT: begin
                m_reg     <= a;
                q_reg     <= b;
                acc_reg   <= '0;
                cnt_reg   <= '0;
                busy_reg  <= 1'b1;
                state_reg <= MUL;
              end
              default: begin
                // NOP and reserved codes complete without touching the flags.
                done_reg <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          acc_reg <= acc_next;
          m_reg   <= {m_reg[WIDTH-2:0], 1'b0};
          q_reg   <= {1'b0, q_reg[WIDTH-1:1]};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            result_reg <= acc_next;
            z_reg      <= (acc_next == '0);
            cout_reg   <= 1'b0;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign result = result_reg;
  assign z      = z_reg;
  assign cout   = cout_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  alu_op = 3'd0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic [15:0] result;
  logic        z;
  logic        cout;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  logic [15:0] m_res = 16'h0;
  logic        m_z = 1'b1;
  logic        m_cout = 1'b0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op),
    .a(a), .b(b), .result(result), .z(z), .cout(cout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definitions.
  task automatic model(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    longint p;
    case (op)
      3'd1: begin
        p = longint'(x) + longint'(y);
        m_res = 16'(p % 65536);
        m_cout = (p > 65535);
      end
      3'd2: begin
        p = longint'(x) - longint'(y) + 65536;
        m_res = 16'(p % 65536);
        m_cout = (x < y);
      end
      3'd3: begin
        p = longint'(x) * longint'(y);
        m_res = 16'(p % 65536);
        m_cout = 1'b0;
      end
      3'd4: begin
        p = longint'(x) * 2;
        m_res = 16'(p % 65536);
        m_cout = (x >= 16'h8000);
      end
      default: ;
    endcase
    m_z = (m_res == 16'h0);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_result"}, result, m_res);
    chk({tag, "_z"}, z, m_z);
    chk({tag, "_cout"}, cout, m_cout);
  endtask

  task automatic do_single(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    alu_op = op; a = x; b = y; start = 1'b1;
    model(op, x, y);
    @(posedge clk); #1;
    start = 1'b0;
    $display("op=%0d a=0x%04h b=0x%04h -> result=0x%04h z=%0b cout=%0b done=%0b",
             op, x, y, result, z, cout, done);
    chk("single_done", done, 1);
    chk("single_busy", busy, 0);
    check_outs("single");
    @(posedge clk); #1;
    chk("single_done_drop", done, 0);
    chk("single_hold", result, m_res);
  endtask

  task automatic do_mul(input logic [15:0] x, input logic [15:0] y, input bit inject);
    @(negedge clk);
    alu_op = 3'd3; a = x; b = y; start = 1'b1;
    model(3'd3, x, y);
    @(posedge clk); #1;
    start = 1'b0;
    chk("mul_busy_start", busy, 1);
    chk("mul_done_start", done, 0);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (inject && cyc == 4) begin
        alu_op = 3'd1; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("mul_busy", busy, (cyc < 16));
      chk("mul_done", done, (cyc == 16));
    end
    $display("op=3 a=0x%04h b=0x%04h inj=%0b -> result=0x%04h z=%0b cout=%0b done=%0b",
             x, y, inject, result, z, cout, done);
    check_outs("mul");
    @(posedge clk); #1;
    chk("mul_done_drop", done, 0);
    chk("mul_hold", result, m_res);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 4))
      0: return 16'hFFFF;
      1: return 16'h0000;
      2: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    logic [15:0] x;
    logic [15:0] y;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_z", z, 1);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_single(3'd1, 16'h1234, 16'h0001);
    do_single(3'd1, 16'hFFFF, 16'h0001);
    do_single(3'd2, 16'd5, 16'd5);
    do_single(3'd2, 16'd3, 16'd5);
    do_single(3'd4, 16'h8001, 16'h0);
    do_single(3'd0, 16'h1111, 16'h2222);
    do_single(3'd7, 16'h0000, 16'h0000);
    do_mul(16'd300, 16'd200, 1'b0);
    chk("mul_300x200", result, 16'hEA60);
    do_mul(16'h0100, 16'h0100, 1'b0);
    chk("mul_trunc_z", z, 1);
    do_mul(16'hFFFF, 16'hFFFF, 1'b1);
    chk("mul_ffff", result, 16'h0001);

    // Back-to-back single-cycle ops with start held high.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case ($urandom_range(0, 2))
        0: op = 3'd1;
        1: op = 3'd2;
        default: op = 3'd4;
      endcase
      alu_op = op; a = pick(); b = pick();
      model(op, a, b);
      @(posedge clk); #1;
      $display("b2b op=%0d a=0x%04h b=0x%04h -> result=0x%04h done=%0b", op, a, b, result, done);
      chk("b2b_done", done, 1);
      check_outs("b2b");
      @(negedge clk);
    end
    start = 1'b0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    alu_op = 3'd3; a = 16'h1234; b = 16'h0567; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_res = 16'h0; m_z = 1'b1; m_cout = 1'b0;
    $display("async reset mid-mult -> result=0x%04h z=%0b busy=%0b done=%0b", result, z, busy, done);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    check_outs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("arst_no_done", done, 0);
    end
    do_single(3'd4, 16'h8001, 16'h0);
    chk("arst_lshift", result, 16'h0002);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      if (op == 3'd3) do_mul(x, y, 1'($urandom_range(0, 1)));
      else do_single(op, x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
